// File: rtl/sys_bus_arbiter.sv
// rtl/sys_bus_arbiter.sv - NUM_CH-way round-robin burst arbiter onto a single busy/wait memory port
// Optional busy-stall abort and sticky err enabled by SYS_BUS_TIMEOUT_EN.
module sys_bus_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int BLEN_W         = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       tbCTRL,
    input  logic [NUM_CH-1:0]          ch_ren,
    input  logic [NUM_CH-1:0]          ch_wen,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_store,
    input  logic [NUM_CH*BLEN_W-1:0]   ch_blen,
    input  logic [NUM_CH-1:0]          ch_halt,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [DATA_W-1:0]          ch_load,
    output logic                       halt,
    output logic                       err,
    output logic                       mem_ren,
    output logic                       mem_wen,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_store,
    input  logic [DATA_W-1:0]          mem_load,
    input  logic                       mem_busy
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t              r_state, w_next;
    logic [GW-1:0]       r_grant, r_last_grant, w_pick, w_idx;
    logic                r_write, r_halt, r_mem_ren, r_mem_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [BLEN_W-1:0]   r_beats_left;
    logic                w_found, w_beat_done, w_g_active, w_timeout, w_write_next;
    logic [NUM_CH-1:0]   w_req;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   w_store_arr [NUM_CH];
    logic [BLEN_W-1:0]   w_blen_arr  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
        assign w_store_arr[g] = ch_store[g*DATA_W +: DATA_W];
        assign w_blen_arr[g]  = ch_blen[g*BLEN_W +: BLEN_W];
    end

    assign w_req       = ch_ren | ch_wen;
    assign w_beat_done = (r_state == S_XFER) && !mem_busy;
    assign w_g_active  = ch_ren[r_grant] | ch_wen[r_grant];

    // Search starts one past the last served channel; halt freezes all new grants.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        if (!r_halt) begin
            if (tbCTRL && w_req[0]) begin
                w_found = 1'b1;
            end else begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    w_idx = GW'((int'(r_last_grant) + k) % NUM_CH);
                    if (!w_found && w_req[w_idx]) begin
                        w_found = 1'b1;
                        w_pick  = w_idx;
                    end
                end
            end
        end
    end

`ifdef SYS_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_err;

    assign w_timeout = (r_state == S_XFER) && mem_busy && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= r_err | w_timeout;
            if (r_state != S_XFER || !mem_busy || w_timeout)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_found) w_next = S_XFER;
            S_XFER: begin
                if (w_timeout)
                    w_next = S_IDLE;
                else if (w_beat_done && (r_beats_left == '0 || !w_g_active))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_write_next = (r_state == S_IDLE) ? ch_wen[w_pick] : r_write;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_CH - 1);
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_halt       <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_halt    <= r_halt | (|ch_halt);
            r_mem_ren <= (w_next == S_XFER) && !w_write_next;
            r_mem_wen <= (w_next == S_XFER) && w_write_next;
            if (r_state == S_IDLE && w_found) begin
                r_grant      <= w_pick;
                r_write      <= ch_wen[w_pick];
                r_addr       <= w_addr_arr[w_pick];
                r_beats_left <= w_blen_arr[w_pick];
            end else if (r_state == S_XFER) begin
                if (w_next == S_IDLE) begin
                    r_last_grant <= r_grant;
                end else if (w_beat_done) begin
                    r_addr       <= r_addr + STEP;
                    r_beats_left <= r_beats_left - 1'b1;
                end
            end
        end
    end

    always_comb begin
        ch_ack  = '0;
        ch_load = '0;
        if (w_beat_done) begin
            ch_ack[r_grant] = 1'b1;
            ch_load         = mem_load;
        end
    end

    assign mem_store = (r_state == S_XFER) ? w_store_arr[r_grant] : '0;
    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_addr;
    assign halt      = r_halt;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb/tb_sys_bus_arbiter.sv - scoreboard bench for sys_bus_arbiter (NUM_CH=2)
module tb_sys_bus_arbiter;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        tbCTRL = 1'b0;
    logic [1:0]  ch_ren = '0, ch_wen = '0, ch_halt = '0;
    logic [63:0] ch_addr = '0, ch_store = '0;
    logic [5:0]  ch_blen = '0;
    logic [1:0]  ch_ack;
    logic [31:0] ch_load, mem_addr, mem_store, mem_load;
    logic        halt, err, mem_ren, mem_wen;
    logic        mem_busy = 1'b0;

    sys_bus_arbiter dut (
        .CLK(CLK), .RST(RST), .tbCTRL(tbCTRL),
        .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_store(ch_store),
        .ch_blen(ch_blen), .ch_halt(ch_halt), .ch_ack(ch_ack), .ch_load(ch_load),
        .halt(halt), .err(err), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;
    assign mem_load = mem_addr ^ KEY;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] addr, input logic [31:0] data, input bit wr);
        exp_t e;
        e.ch = ch; e.addr = addr; e.data = data; e.wr = wr;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!RST && ch_ack != 2'b00) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {62'd0, ch_ack}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_ch", {62'd0, ch_ack}, 64'd1 << e.ch);
                check("ack_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                if (e.wr) begin
                    check("ack_wen", {63'd0, mem_wen}, 64'd1);
                    check("ack_store", {32'd0, mem_store}, {32'd0, e.data});
                end else begin
                    check("ack_load", {32'd0, ch_load}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && q.size() != 0; c++) tick();
        check("drain", 64'(q.size()), 64'd0);
    endtask

    int b;

    initial begin
        do_reset();
        @(negedge CLK);
        check("rst_ack", {62'd0, ch_ack}, 64'd0);
        check("rst_strobes", {62'd0, mem_ren, mem_wen}, 64'd0);
        check("rst_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_halt_err", {62'd0, halt, err}, 64'd0);

        // single read on ch1
        tick();
        ch_addr[63:32] = 32'h100; ch_blen[5:3] = 3'd0; ch_ren[1] = 1'b1;
        push(1, 32'h100, 32'h100 ^ KEY, 1'b0);
        tick();
        ch_ren[1] = 1'b0;
        @(negedge CLK);
        check("rd_ren_n1", {63'd0, mem_ren}, 64'd1);
        tick();
        @(negedge CLK);
        check("rd_ren_n2", {63'd0, mem_ren}, 64'd0);
        check("rd_drain", 64'(q.size()), 64'd0);

        // 4-beat write on ch0 with one busy cycle on the second beat
        ch_addr[31:0] = 32'h200; ch_blen[2:0] = 3'd3; ch_wen[0] = 1'b1;
        for (int j = 0; j < 4; j++) push(0, 32'h200 + 32'(4*j), 32'hD000_0000 + 32'(j), 1'b1);
        b = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_busy = (i == 1);
            ch_store[31:0] = 32'hD000_0000 + 32'(b);
            if (i == 4) ch_wen[0] = 1'b0;
            @(negedge CLK);
            check("bw_wen", {63'd0, mem_wen}, 64'd1);
            check("bw_addr", {32'd0, mem_addr}, {32'd0, 32'h200 + 32'(4*b)});
            if (!mem_busy) b++;
        end
        mem_busy = 1'b0;
        tick();
        @(negedge CLK);
        check("bw_end", {63'd0, mem_wen}, 64'd0);
        check("bw_drain", 64'(q.size()), 64'd0);

        // round-robin: last grant was ch0, so ch1 goes first
        ch_addr[31:0] = 32'h300; ch_addr[63:32] = 32'h400; ch_blen = '0;
        push(1, 32'h400, 32'h400 ^ KEY, 1'b0);
        push(0, 32'h300, 32'h300 ^ KEY, 1'b0);
        push(1, 32'h400, 32'h400 ^ KEY, 1'b0);
        push(0, 32'h300, 32'h300 ^ KEY, 1'b0);
        ch_ren = 2'b11;
        wait_drain(40);
        ch_ren = 2'b00;
        tick();

        // tbCTRL priority starves ch1
        tbCTRL = 1'b1;
        for (int j = 0; j < 3; j++) push(0, 32'h300, 32'h300 ^ KEY, 1'b0);
        ch_ren = 2'b11;
        wait_drain(40);
        ch_ren = 2'b00;
        tbCTRL = 1'b0;
        tick();

        // halt pulse mid-burst: burst completes, then no grants
        ch_addr[31:0] = 32'h500; ch_blen[2:0] = 3'd3; ch_store[31:0] = 32'h5A5A_0000;
        for (int j = 0; j < 4; j++) push(0, 32'h500 + 32'(4*j), 32'h5A5A_0000, 1'b1);
        ch_wen[0] = 1'b1;
        tick();
        tick();
        ch_halt[1] = 1'b1;
        tick();
        ch_halt[1] = 1'b0;
        tick();
        ch_wen[0] = 1'b0;
        ch_ren[1] = 1'b1;
        repeat (10) tick();
        @(negedge CLK);
        check("halt_set", {63'd0, halt}, 64'd1);
        check("halt_no_grant", {63'd0, mem_ren}, 64'd0);
        check("halt_drain", 64'(q.size()), 64'd0);
        ch_ren = 2'b00;
        do_reset();
        @(negedge CLK);
        check("halt_cleared", {63'd0, halt}, 64'd0);

        // reset during beat 2 of 4; ch0 wins first after release
        ch_addr[31:0] = 32'h600; ch_blen[2:0] = 3'd3;
        push(0, 32'h600, 32'h600 ^ KEY, 1'b0);
        ch_ren[0] = 1'b1;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ch_blen = '0;
        ch_ren = 2'b11;
        @(negedge CLK);
        check("rstmid_strobes", {62'd0, mem_ren, mem_wen}, 64'd0);
        check("rstmid_ack", {62'd0, ch_ack}, 64'd0);
        check("rstmid_addr", {32'd0, mem_addr}, 64'd0);
        check("rstmid_drain", 64'(q.size()), 64'd0);
        push(0, 32'h600, 32'h600 ^ KEY, 1'b0);
        push(1, 32'h400, 32'h400 ^ KEY, 1'b0);
        wait_drain(20);
        ch_ren = 2'b00;
        tick();

        // memory held busy for 80 cycles
        mem_busy = 1'b1;
        ch_ren[1] = 1'b1;
        tick();
        ch_ren[1] = 1'b0;
        repeat (80) tick();
        @(negedge CLK);
`ifdef SYS_BUS_TIMEOUT_EN
        check("to_err", {63'd0, err}, 64'd1);
        check("to_abort", {63'd0, mem_ren}, 64'd0);
        mem_busy = 1'b0;
        repeat (3) tick();
`else
        check("to_err", {63'd0, err}, 64'd0);
        check("to_wait", {63'd0, mem_ren}, 64'd1);
        push(1, 32'h400, 32'h400 ^ KEY, 1'b0);
        tick();
        mem_busy = 1'b0;
        wait_drain(5);
        tick();
`endif
        @(negedge CLK);
        check("final_idle", {62'd0, mem_ren, mem_wen}, 64'd0);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Parametrised successor to the single-port system interface: arbitrates NUM_CH requesters (channel 0 = testbench, others = cores/DMA) onto one memory port with a busy/wait handshake, incrementing-address bursts and a sticky system halt. Sits between the testbench/datapath request sources and the RAM model. tbCTRL keeps its role of giving the testbench channel priority.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; address step per beat = DATA_W/8
- BLEN_W, 3, burst-length field width (beats = blen+1, max 2^BLEN_W)
- TIMEOUT_CYCLES, 64, busy-stall limit (used only with SYS_BUS_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- tbCTRL  in  1  channel 0 wins every arbitration while high
- ch_ren  in  NUM_CH  read request per channel
- ch_wen  in  NUM_CH  write request per channel; wins over ch_ren on same channel
- ch_addr  in  NUM_CH*ADDR_W  start address, channel i at bits [i*ADDR_W +: ADDR_W]
- ch_store  in  NUM_CH*DATA_W  write data, sampled live each beat
- ch_blen  in  NUM_CH*BLEN_W  burst length minus one
- ch_halt  in  NUM_CH  halt request
- ch_ack  out  NUM_CH  one-hot one-cycle pulse per completed beat
- ch_load  out  DATA_W  read data, valid while granted ch_ack high
- halt  out  1  sticky halt
- err  out  1  sticky timeout error
- mem_ren, mem_wen  out  1  memory strobes (registered)
- mem_addr  out  ADDR_W; mem_store  out  DATA_W
- mem_load  in  DATA_W; mem_busy  in  1  memory not ready this cycle

## Operation
- States: IDLE, XFER.
- IDLE: request = ch_ren|ch_wen. If halt set: no grant. Else if tbCTRL and channel 0 requests: grant 0. Else round-robin from last_grant+1. On grant: latch grant index, op (write if wen), ch_addr, beats_left=ch_blen; go XFER.
- XFER: mem_ren/mem_wen/mem_addr driven from registers; mem_store = ch_store of granted channel. Beat completes when mem_busy==0: ch_ack[grant]=1, ch_load=mem_load.
- After beat: beats_left==0 -> IDLE, last_grant=grant, strobes drop next cycle. Else addr += DATA_W/8 (wraps modulo 2^ADDR_W), beats_left--.
- Requester drops both ren/wen while in XFER: current beat finishes normally, then IDLE (early termination, no ack for remaining beats).
- No preemption mid-burst, including by tbCTRL.
- ch_halt any bit high: halt set next cycle, cleared only by RST; in-flight burst completes, then no further grants.
- Reset: state IDLE, all outputs 0, last_grant=NUM_CH-1 (channel 0 first), halt=0, err=0.

## Timing
- Request seen in IDLE at cycle N -> mem strobes at N+1 -> earliest ch_ack at N+1 (mem_busy low).
- Bursts: one beat per cycle while mem_busy low; each busy cycle adds one cycle.
- Back-to-back transactions: one IDLE cycle between bursts (min 2 cycles/transaction).
- ch_ack and ch_load combinational from mem_busy/mem_load in XFER; all other outputs registered.
- RST mid-burst: next cycle state IDLE, strobes 0, no ack.

## Configuration
- SYS_BUS_TIMEOUT_EN defined: counter increments each XFER cycle with mem_busy high, clears on beat completion. Reaching TIMEOUT_CYCLES: burst aborted, no ack, state IDLE next cycle, err set (sticky until RST).
- Undefined: no counter, err tied 0, XFER waits indefinitely.

## Test plan
- Single read: ch1 ren, addr 0x100, blen 0, mem_busy 0 -> mem_ren at N+1, ch_ack[1] at N+1 with ch_load=mem_load, IDLE at N+2.
- Burst write: ch0 wen, addr 0x200, blen 3, busy high on 2nd beat one cycle -> mem_addr 0x200,0x204,0x204,0x208,0x20C; four acks; 5 XFER cycles.
- Round-robin: ch0 and ch1 request continuously, tbCTRL 0 -> grants alternate 0,1,0,1; with tbCTRL 1 -> always 0, ch1 starved.
- Halt: ch_halt[1] pulse during ch0 4-beat burst -> burst finishes all 4 acks, halt=1, no further grants until RST.
- Timeout (macro on, TIMEOUT_CYCLES 64): mem_busy held high -> abort after 64 busy cycles, err=1, no ch_ack; macro off -> waits, err=0.
- Reset mid-burst: RST during beat 2 of 4 -> strobes 0, state IDLE, all outputs 0 next cycle; ch0 granted first after release.
